// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin core.
package dmem_arbiter_pkg;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } dmem_port_e;

    localparam logic [3:0] DMEM_WSTRB_NONE = 4'b0000;

    // Round-robin choice: on a conflict the port that did not win last time goes next.
    function automatic dmem_port_e rr_pick(input logic [1:0] req, input dmem_port_e last);
        if (req[0] && req[1]) begin
            return (last == PORT_CORE) ? PORT_DBG : PORT_CORE;
        end else if (req[1]) begin
            return PORT_DBG;
        end else begin
            return PORT_CORE;
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a registered last-grant pointer; reusable
// for any shared resource that takes at most one access per cycle.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       accept,
    output dmem_port_e grant_port
);

    dmem_port_e last_grant;

    always_comb begin
        grant      = '0;
        grant_port = rr_pick(req, last_grant);
        if (req != '0) begin
            grant[grant_port] = 1'b1;
        end
        accept = |grant;
    end

    // Reset to the debug port so the core wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_DBG;
        end else if (accept) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_mem between the core load/store path and the debug/loader path.
// Optional address range check: define DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 256
) (
    input  logic                  Clk_Core,
    input  logic                  Rst_Core,

    input  logic                  Core_Req_Valid,
    output logic                  Core_Req_Ready,
    input  logic                  Core_Req_Write,
    input  logic [ADDR_WIDTH-1:0] Core_Req_Addr,
    input  logic [31:0]           Core_Req_Wdata,
    input  logic [3:0]            Core_Req_Wstrb,
    output logic                  Core_Rsp_Valid,
    output logic [31:0]           Core_Rsp_Rdata,
    output logic                  Core_Rsp_Err,

    input  logic                  Dbg_Req_Valid,
    output logic                  Dbg_Req_Ready,
    input  logic                  Dbg_Req_Write,
    input  logic [ADDR_WIDTH-1:0] Dbg_Req_Addr,
    input  logic [31:0]           Dbg_Req_Wdata,
    input  logic [3:0]            Dbg_Req_Wstrb,
    output logic                  Dbg_Rsp_Valid,
    output logic [31:0]           Dbg_Rsp_Rdata,
    output logic                  Dbg_Rsp_Err,

    output logic                  Mem_Read_Ctrl,
    output logic [3:0]            Mem_Write_Ctrl,
    output logic [ADDR_WIDTH-1:0] Mem_Data_Address,
    output logic [31:0]           Mem_Data_Write,
    input  logic [31:0]           Mem_Data_Read
);

    if (MEM_SIZE == 0) begin : g_bad_mem_size
        $error("dmem_arbiter: MEM_SIZE must be non-zero");
    end

    logic [1:0]            grant;
    logic                  accept;
    dmem_port_e            grant_port;

    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic [3:0]            sel_wstrb;
    logic                  out_of_range;

    logic                  rsp_owner_valid;
    dmem_port_e            rsp_owner;
    logic                  rsp_is_read;
    logic                  rsp_err_q;
    logic [31:0]           rsp_rdata;
    logic                  core_owns;
    logic                  dbg_owns;

    rr_arb2 u_rr_arb2 (
        .clk        (Clk_Core),
        .rst        (Rst_Core),
        .req        ({Dbg_Req_Valid, Core_Req_Valid}),
        .grant      (grant),
        .accept     (accept),
        .grant_port (grant_port)
    );

    assign Core_Req_Ready = grant[PORT_CORE];
    assign Dbg_Req_Ready  = grant[PORT_DBG];

    always_comb begin
        if (grant_port == PORT_DBG) begin
            sel_write = Dbg_Req_Write;
            sel_addr  = Dbg_Req_Addr;
            sel_wdata = Dbg_Req_Wdata;
            sel_wstrb = Dbg_Req_Wstrb;
        end else begin
            sel_write = Core_Req_Write;
            sel_addr  = Core_Req_Addr;
            sel_wdata = Core_Req_Wdata;
            sel_wstrb = Core_Req_Wstrb;
        end
    end

`ifdef DMEM_ARB_RANGE_CHECK_EN
    // One extra bit so MEM_SIZE*4 == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE * 4);

    assign out_of_range = ({1'b0, sel_addr} >= ADDR_LIMIT);

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= accept && out_of_range;
        end
    end
`else
    assign out_of_range = 1'b0;
    assign rsp_err_q    = 1'b0;
`endif

    always_comb begin
        Mem_Read_Ctrl    = 1'b0;
        Mem_Write_Ctrl   = DMEM_WSTRB_NONE;
        Mem_Data_Address = '0;
        Mem_Data_Write   = '0;
        if (accept) begin
            Mem_Data_Address = sel_addr;
            Mem_Data_Write   = sel_wdata;
            if (!out_of_range) begin
                Mem_Read_Ctrl  = !sel_write;
                Mem_Write_Ctrl = sel_write ? sel_wstrb : DMEM_WSTRB_NONE;
            end
        end
    end

    // Rejected accesses are never treated as reads, so their data returns as 0.
    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            rsp_owner_valid <= 1'b0;
            rsp_owner       <= PORT_CORE;
            rsp_is_read     <= 1'b0;
        end else begin
            rsp_owner_valid <= accept;
            if (accept) begin
                rsp_owner   <= grant_port;
                rsp_is_read <= !sel_write && !out_of_range;
            end
        end
    end

    always_comb begin
        core_owns      = rsp_owner_valid && (rsp_owner == PORT_CORE);
        dbg_owns       = rsp_owner_valid && (rsp_owner == PORT_DBG);
        rsp_rdata      = rsp_is_read ? Mem_Data_Read : '0;

        Core_Rsp_Valid = core_owns;
        Core_Rsp_Rdata = core_owns ? rsp_rdata : '0;
        Core_Rsp_Err   = core_owns && rsp_err_q;

        Dbg_Rsp_Valid  = dbg_owns;
        Dbg_Rsp_Rdata  = dbg_owns ? rsp_rdata : '0;
        Dbg_Rsp_Err    = dbg_owns && rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios followed by random traffic,
// with a behavioural data_mem and reference memory kept in the bench.
module tb_dmem_arbiter;

    logic        Clk_Core = 1'b0;
    logic        Rst_Core = 1'b0;

    logic        Core_Req_Valid = 1'b0, Core_Req_Ready, Core_Req_Write = 1'b0;
    logic [31:0] Core_Req_Addr = '0, Core_Req_Wdata = '0;
    logic [3:0]  Core_Req_Wstrb = '0;
    logic        Core_Rsp_Valid, Core_Rsp_Err;
    logic [31:0] Core_Rsp_Rdata;

    logic        Dbg_Req_Valid = 1'b0, Dbg_Req_Ready, Dbg_Req_Write = 1'b0;
    logic [31:0] Dbg_Req_Addr = '0, Dbg_Req_Wdata = '0;
    logic [3:0]  Dbg_Req_Wstrb = '0;
    logic        Dbg_Rsp_Valid, Dbg_Rsp_Err;
    logic [31:0] Dbg_Rsp_Rdata;

    logic        Mem_Read_Ctrl;
    logic [3:0]  Mem_Write_Ctrl;
    logic [31:0] Mem_Data_Address, Mem_Data_Write;
    logic [31:0] Mem_Data_Read = '0;

    dmem_arbiter #(.ADDR_WIDTH(32), .MEM_SIZE(256)) dut (
        .Clk_Core(Clk_Core), .Rst_Core(Rst_Core),
        .Core_Req_Valid(Core_Req_Valid), .Core_Req_Ready(Core_Req_Ready), .Core_Req_Write(Core_Req_Write),
        .Core_Req_Addr(Core_Req_Addr), .Core_Req_Wdata(Core_Req_Wdata), .Core_Req_Wstrb(Core_Req_Wstrb),
        .Core_Rsp_Valid(Core_Rsp_Valid), .Core_Rsp_Rdata(Core_Rsp_Rdata), .Core_Rsp_Err(Core_Rsp_Err),
        .Dbg_Req_Valid(Dbg_Req_Valid), .Dbg_Req_Ready(Dbg_Req_Ready), .Dbg_Req_Write(Dbg_Req_Write),
        .Dbg_Req_Addr(Dbg_Req_Addr), .Dbg_Req_Wdata(Dbg_Req_Wdata), .Dbg_Req_Wstrb(Dbg_Req_Wstrb),
        .Dbg_Rsp_Valid(Dbg_Rsp_Valid), .Dbg_Rsp_Rdata(Dbg_Rsp_Rdata), .Dbg_Rsp_Err(Dbg_Rsp_Err),
        .Mem_Read_Ctrl(Mem_Read_Ctrl), .Mem_Write_Ctrl(Mem_Write_Ctrl),
        .Mem_Data_Address(Mem_Data_Address), .Mem_Data_Write(Mem_Data_Write),
        .Mem_Data_Read(Mem_Data_Read)
    );

    always #5 Clk_Core = ~Clk_Core;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int unsigned due;
    } rsp_t;

    rsp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    bit          run = 1'b0;
    bit          fill = 1'b0;
    logic [31:0] dmem [256];
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] init_word(input int unsigned i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 2) return 32'hCAFEBABE;
        if (i == 4) return 32'hDEADBEEF;
        return {b, 8'h5A, ~b, 8'hC3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge Clk_Core) cyc <= cyc + 1;

    // Behavioural data_mem: read data one cycle after Mem_Read_Ctrl, byte-lane writes.
    always @(posedge Clk_Core) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
        end else begin
            if (Mem_Read_Ctrl) Mem_Data_Read <= dmem[Mem_Data_Address[9:2]];
            for (int b = 0; b < 4; b++)
                if (Mem_Write_Ctrl[b]) dmem[Mem_Data_Address[9:2]][8*b +: 8] <= Mem_Data_Write[8*b +: 8];
        end
    end

    // Request-side reference: who should win, what memory should see, what comes back.
    bit          m_last = 1'b1;
    bit          m_gc, m_gd, m_w, m_oor;
    logic [31:0] m_a, m_d;
    logic [3:0]  m_s;
    rsp_t        m_e;

    always @(negedge Clk_Core) begin
        if (Rst_Core) begin
            m_last = 1'b1;
        end else if (run) begin
            m_gc = Core_Req_Valid && (!Dbg_Req_Valid || m_last);
            m_gd = Dbg_Req_Valid && !m_gc;
            chk("core_ready", Core_Req_Ready, 32'(m_gc));
            chk("dbg_ready", Dbg_Req_Ready, 32'(m_gd));
            if (m_gc || m_gd) begin
                m_w = m_gd ? Dbg_Req_Write : Core_Req_Write;
                m_a = m_gd ? Dbg_Req_Addr  : Core_Req_Addr;
                m_d = m_gd ? Dbg_Req_Wdata : Core_Req_Wdata;
                m_s = m_gd ? Dbg_Req_Wstrb : Core_Req_Wstrb;
`ifdef DMEM_ARB_RANGE_CHECK_EN
                m_oor = (m_a >= 32'd1024);
`else
                m_oor = 1'b0;
`endif
                chk("mem_addr", Mem_Data_Address, m_a);
                chk("mem_wdata", Mem_Data_Write, m_d);
                chk("mem_read_ctrl", Mem_Read_Ctrl, 32'(!m_w && !m_oor));
                chk("mem_write_ctrl", Mem_Write_Ctrl, (m_w && !m_oor) ? 32'(m_s) : 32'd0);
                m_e.port  = m_gd;
                m_e.rdata = (!m_w && !m_oor) ? ref_mem[m_a[9:2]] : 32'd0;
                m_e.err   = m_oor;
                m_e.due   = cyc + 1;
                exp_q.push_back(m_e);
                if (m_w && !m_oor)
                    for (int b = 0; b < 4; b++)
                        if (m_s[b]) ref_mem[m_a[9:2]][8*b +: 8] = m_d[8*b +: 8];
                m_last = m_gd;
            end else begin
                chk("idle_mem_ctrl", {Mem_Write_Ctrl, 3'b0, Mem_Read_Ctrl}, 32'd0);
                chk("idle_mem_addr", Mem_Data_Address | Mem_Data_Write, 32'd0);
            end
        end
    end

    // Response monitor: pops whatever is due this cycle and compares both ports.
    rsp_t        r_e;
    bit          r_cv, r_dv;
    logic [31:0] r_data;
    bit          r_err;

    always @(negedge Clk_Core) begin
        if (Rst_Core) begin
            exp_q.delete();
        end else if (run) begin
            r_cv = 1'b0; r_dv = 1'b0; r_data = '0; r_err = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                r_e    = exp_q.pop_front();
                r_cv   = (r_e.port == 1'b0);
                r_dv   = (r_e.port == 1'b1);
                r_data = r_e.rdata;
                r_err  = r_e.err;
            end
            chk("core_rsp_valid", Core_Rsp_Valid, 32'(r_cv));
            chk("dbg_rsp_valid", Dbg_Rsp_Valid, 32'(r_dv));
            chk("core_rsp_rdata", Core_Rsp_Rdata, r_cv ? r_data : 32'd0);
            chk("dbg_rsp_rdata", Dbg_Rsp_Rdata, r_dv ? r_data : 32'd0);
            chk("core_rsp_err", Core_Rsp_Err, 32'(r_cv && r_err));
            chk("dbg_rsp_err", Dbg_Rsp_Err, 32'(r_dv && r_err));
        end
    end

    task automatic drive(input bit cv, input bit cw, input logic [31:0] ca, input logic [31:0] cd, input logic [3:0] cs,
                         input bit dv, input bit dw, input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds);
        Core_Req_Valid = cv; Core_Req_Write = cw; Core_Req_Addr = ca; Core_Req_Wdata = cd; Core_Req_Wstrb = cs;
        Dbg_Req_Valid  = dv; Dbg_Req_Write  = dw; Dbg_Req_Addr  = da; Dbg_Req_Wdata  = dd; Dbg_Req_Wstrb  = ds;
        @(posedge Clk_Core);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    function automatic logic [31:0] rand_addr();
`ifdef DMEM_ARB_RANGE_CHECK_EN
        if ($urandom_range(0, 9) == 0) return 32'h400 + (32'($urandom_range(0, 63)) << 2);
`endif
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 7)) << 2;
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    bit hold_c, hold_d;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        fill = 1'b1;
        #2 Rst_Core = 1'b1;
        #1;
        chk("reset_core_rsp_valid", Core_Rsp_Valid, 0);
        chk("reset_dbg_rsp_valid", Dbg_Rsp_Valid, 0);
        chk("reset_rsp_rdata", Core_Rsp_Rdata | Dbg_Rsp_Rdata, 0);
        chk("reset_rsp_err", 32'(Core_Rsp_Err | Dbg_Rsp_Err), 0);
        chk("reset_mem_ctrl", {Mem_Write_Ctrl, 3'b0, Mem_Read_Ctrl}, 0);
        repeat (3) @(posedge Clk_Core);
        fill = 1'b0;
        #1 Rst_Core = 1'b0;
        run = 1'b1;
        idle(2);

        // Core store then load.
        drive(1, 1, 32'h04, 32'hAABBCCDD, 4'hF, 0, 0, '0, '0, '0);
        drive(1, 0, 32'h04, '0, '0, 0, 0, '0, '0, '0);
        idle(2);

        // Reset lands between accept and response.
        drive(1, 0, 32'h04, '0, '0, 0, 0, '0, '0, '0);
        Core_Req_Valid = 1'b0;
        chk("rsp_before_reset", Core_Rsp_Valid, 1);
        Rst_Core = 1'b1;
        #1;
        chk("rst_async_valid", Core_Rsp_Valid, 0);
        chk("rst_async_rdata", Core_Rsp_Rdata, 0);
        @(posedge Clk_Core);
        #1 Rst_Core = 1'b0;

        // Both ports persistently read 0x08: core, dbg, core, dbg.
        repeat (4) drive(1, 0, 32'h08, '0, '0, 1, 0, 32'h08, '0, '0);
        idle(2);

        // Byte-lane store from debug, then core load sees the merged word.
        drive(0, 0, '0, '0, '0, 1, 1, 32'h10, 32'h00AA0000, 4'b0100);
        drive(1, 0, 32'h10, '0, '0, 0, 0, '0, '0, '0);
        idle(1);

        // Back-to-back core reads.
        drive(1, 0, 32'h04, '0, '0, 0, 0, '0, '0, '0);
        drive(1, 0, 32'h08, '0, '0, 0, 0, '0, '0, '0);
        idle(1);

        // Write with no byte lanes enabled still gets a response.
        drive(0, 0, '0, '0, '0, 1, 1, 32'h0C, 32'h12345678, 4'b0000);
        drive(1, 0, 32'h0C, '0, '0, 0, 0, '0, '0, '0);
        idle(1);

`ifdef DMEM_ARB_RANGE_CHECK_EN
        drive(0, 0, '0, '0, '0, 1, 1, 32'h400, 32'hFFFFFFFF, 4'hF);
        drive(0, 0, '0, '0, '0, 1, 0, 32'h000, '0, '0);
        idle(1);
`endif

        // Random traffic; a request not yet accepted is held stable.
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk_Core);
            hold_c = Core_Req_Valid && !Core_Req_Ready;
            hold_d = Dbg_Req_Valid && !Dbg_Req_Ready;
            @(posedge Clk_Core);
            #1;
            if (!hold_c) begin
                Core_Req_Valid = ($urandom_range(0, 3) != 0);
                Core_Req_Write = 1'($urandom_range(0, 1));
                Core_Req_Addr  = rand_addr();
                Core_Req_Wdata = $urandom;
                Core_Req_Wstrb = 4'($urandom_range(0, 15));
            end
            if (!hold_d) begin
                Dbg_Req_Valid = ($urandom_range(0, 2) != 0);
                Dbg_Req_Write = 1'($urandom_range(0, 1));
                Dbg_Req_Addr  = rand_addr();
                Dbg_Req_Wdata = $urandom;
                Dbg_Req_Wstrb = 4'($urandom_range(0, 15));
            end
        end
        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
